// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw board-side inputs and the frame-aligned player controls.
interface button_conditioner_if;
  logic [5:0] btn_raw;
  logic       vsync;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       chop;
  logic       carry;

  modport master (
    output btn_raw, vsync,
    input  left, right, up, down, chop, carry
  );

  modport slave (
    input  btn_raw, vsync,
    output left, right, up, down, chop, carry
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and frame-align the six push buttons; chop/carry become one-frame pulses.
// Optional OPPOSING_CANCEL_EN: opposing direction pairs held together are both suppressed.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       btn_s1, btn_s2;
  logic             vsync_s1, vsync_s2, vsync_s3;
  logic [5:0]       stable;
  logic [CNT_W-1:0] cnt [6];
  logic [1:0]       act_d;
  logic             chop_pend, carry_pend;
  logic             fb, press_chop, press_carry;
  logic [3:0]       dir_next;
  logic [3:0]       dir_q;
  logic             chop_q, carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      vsync_s3 <= 1'b0;
    end else begin
      btn_s1   <= bus.btn_raw;
      btn_s2   <= btn_s1;
      vsync_s1 <= bus.vsync;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      act_d  <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      act_d <= stable[5:4];
      for (int unsigned i = 0; i < 6; i++) begin
        if (btn_s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= btn_s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    fb          = vsync_s2 & ~vsync_s3;
    press_chop  = stable[4] & ~act_d[0];
    press_carry = stable[5] & ~act_d[1];
    dir_next    = stable[3:0];
`ifdef OPPOSING_CANCEL_EN
    if (stable[0] & stable[1]) dir_next[1:0] = '0;
    if (stable[2] & stable[3]) dir_next[3:2] = '0;
`endif
  end

  // Pending is cleared by fb but re-set by a same-cycle press, so a colliding press lands next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= '0;
      chop_q     <= 1'b0;
      carry_q    <= 1'b0;
      chop_pend  <= 1'b0;
      carry_pend <= 1'b0;
    end else begin
      if (fb) begin
        dir_q   <= dir_next;
        chop_q  <= chop_pend;
        carry_q <= carry_pend;
      end
      chop_pend  <= (chop_pend  & ~fb) | press_chop;
      carry_pend <= (carry_pend & ~fb) | press_carry;
    end
  end

  assign bus.left  = dir_q[0];
  assign bus.right = dir_q[1];
  assign bus.up    = dir_q[2];
  assign bus.down  = dir_q[3];
  assign bus.chop  = chop_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: DEBOUNCE_CYCLES=8, 200-cycle vsync frame driven in lockstep.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   ph;
  int   vectors = 0;
  int   errors  = 0;
  logic [5:0] outs;

  button_conditioner_if bus ();

  button_conditioner #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign outs = {bus.carry, bus.chop, bus.down, bus.up, bus.right, bus.left};

`ifdef OPPOSING_CANCEL_EN
  localparam logic [5:0] E_ALL = 6'h00, E_LRU = 6'h04, E_RUD = 6'h02;
`else
  localparam logic [5:0] E_ALL = 6'h0F, E_LRU = 6'h07, E_RUD = 6'h0E;
`endif

  // vsync low for phases 190..199; it rises as ph wraps to 0, outputs update after ph 3's edge
  task automatic step();
    @(posedge clk);
    #1;
    ph        = (ph == 199) ? 0 : ph + 1;
    bus.vsync = (ph < 190);
  endtask

  task automatic run_to(input int target);
    step();
    while (ph != target) step();
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    vectors++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (ph=%0d)", tag, outs, exp, ph);
    end
  endtask

  initial begin
    ph          = 100;
    bus.vsync   = 1'b1;
    bus.btn_raw = 6'h3F;
    reset       = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold", 6'h00);
    end
    reset = 1'b0;

    run_to(150); chk("post_reset_mid", 6'h00);
    run_to(199); chk("post_reset_vs_low", 6'h00);
    run_to(2);   chk("pre_first_fb", 6'h00);
    step();      chk("first_fb_all", E_ALL | 6'h30);
    run_to(100); chk("first_frame_mid", E_ALL | 6'h30);
    run_to(2);   chk("first_frame_end", E_ALL | 6'h30);
    step();      chk("held_no_repeat", E_ALL);
    bus.btn_raw = 6'h00;
    run_to(3);   chk("release_all", 6'h00);

    run_to(10);
    for (int k = 0; k < 10; k++) begin
      bus.btn_raw = (k % 2 == 0) ? 6'h01 : 6'h00;
      repeat (3) step();
    end
    bus.btn_raw = 6'h00;
    run_to(3);   chk("bounce_reject", 6'h00);

    run_to(50);
    bus.btn_raw = 6'h10;
    repeat (7) step();
    bus.btn_raw = 6'h00;
    run_to(3);   chk("glitch_7_reject", 6'h00);

    run_to(50);
    bus.btn_raw = 6'h10;
    repeat (8) step();
    bus.btn_raw = 6'h00;
    run_to(2);   chk("press_8_before_fb", 6'h00);
    step();      chk("press_8_accept", 6'h10);
    run_to(3);   chk("press_8_one_frame", 6'h00);

    run_to(10);
    bus.btn_raw = 6'h04;
    run_to(2);   chk("up_before_fb", 6'h00);
    step();      chk("up_at_fb", 6'h04);
    run_to(3);   chk("up_held", 6'h04);

    run_to(10);
    bus.btn_raw = 6'h07;
    run_to(3);   chk("left_right_up", E_LRU);
    run_to(10);
    bus.btn_raw = 6'h0E;
    run_to(3);   chk("right_up_down", E_RUD);
    run_to(10);
    bus.btn_raw = 6'h00;
    run_to(3);   chk("dirs_released", 6'h00);

    run_to(50);
    bus.btn_raw = 6'h10;
    run_to(3);   chk("chop_hold_fb1", 6'h10);
    run_to(100); chk("chop_hold_mid", 6'h10);
    run_to(2);   chk("chop_hold_end", 6'h10);
    step();      chk("chop_hold_fb2", 6'h00);
    run_to(150);
    bus.btn_raw = 6'h00;
    run_to(3);   chk("chop_hold_fb3", 6'h00);

    // chop stabilises one cycle before fb, carry on the fb cycle itself
    run_to(191);
    bus.btn_raw = 6'h10;
    step();
    bus.btn_raw = 6'h30;
    run_to(3);   chk("collide_frame0", 6'h10);
    run_to(10);
    bus.btn_raw = 6'h00;
    run_to(3);   chk("collide_frame1", 6'h20);

    run_to(20);
    bus.btn_raw = 6'h10;
    repeat (12) step();
    bus.btn_raw = 6'h00;
    run_to(100); chk("pre_mid_reset", 6'h20);
    reset = 1'b1;
    step();      chk("mid_reset", 6'h00);
    reset = 1'b0;
    run_to(3);   chk("pend_discarded", 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
